// File: rtl/counter_bank_pkg.sv
// Shared constants for the counter bank: terminal-count modes and config register selects.
package counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_STOP   = 2'd1,
    MODE_FREE   = 2'd2,
    MODE_RELOAD = 2'd3
  } mode_e;

  localparam logic [1:0] REG_MAX     = 2'd0;
  localparam logic [1:0] REG_LOAD    = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_FLAGCLR = 2'd3;

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with its own max, reload value, mode and sticky terminal flag.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             strobe_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_reg_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] count_o,
  output logic             compare_o,
  output logic             tc_flag_o
);

  logic [WIDTH-1:0] count_q, count_d, max_q, max_d, load_q, load_d;
  mode_e            mode_q, mode_d;
  logic             flag_q, flag_d;
  logic             step, reach_term, tc_set;
  logic [WIDTH-1:0] inc_dec;

  assign compare_o  = up_i ? (count_q == max_q) : (count_q == '0);
  // Stop mode parks at terminal, so the strobe is swallowed there.
  assign step       = strobe_i & enable_i & ~((mode_q == MODE_STOP) & compare_o);
  assign inc_dec    = up_i ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
  assign reach_term = up_i ? (inc_dec == max_q) : (inc_dec == '0);
  // A load overrides any step, so it never raises the flag.
  assign tc_set     = ~load_i & step & (compare_o | ((mode_q == MODE_STOP) & reach_term));

  // Next count, config registers and flag; config writes see the pre-edge values.
  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    load_d  = load_q;
    mode_d  = mode_q;
    flag_d  = flag_q | tc_set;
    if (load_i) begin
      count_d = load_q;
    end else if (step) begin
      if (compare_o) begin
        unique case (mode_q)
          MODE_WRAP:   count_d = up_i ? '0 : max_q;
          MODE_RELOAD: count_d = load_q;
          default:     count_d = inc_dec;
        endcase
      end else begin
        count_d = inc_dec;
      end
    end
    if (wr_en_i) begin
      unique case (wr_reg_i)
        REG_MAX:  max_d  = wr_data_i;
        REG_LOAD: load_d = wr_data_i;
        REG_CTRL: mode_d = mode_e'(wr_data_i[1:0]);
        default:  if (!tc_set) flag_d = 1'b0;
      endcase
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      max_q   <= '1;
      load_q  <= '0;
      mode_q  <= MODE_WRAP;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      load_q  <= load_d;
      mode_q  <= mode_d;
      flag_q  <= flag_d;
    end
  end

  assign count_o   = count_q;
  assign tc_flag_o = flag_q;

endmodule

// File: rtl/counter_bank.sv
// Multi-channel programmable counter/timer: shared tick prescaler feeding CHANNELS counters.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          tick,
  input  logic [PRESCALE_W-1:0]         prescaleDiv,
  input  logic                          cfgWrEn,
  input  logic [$clog2(CHANNELS)-1:0]   cfgChan,
  input  logic [1:0]                    cfgReg,
  input  logic [WIDTH-1:0]              cfgData,
  input  logic [CHANNELS-1:0]           chanEnable,
  input  logic [CHANNELS-1:0]           chanLoad,
  input  logic [CHANNELS-1:0]           upNotDown,
  output logic [CHANNELS*WIDTH-1:0]     countValue,
  output logic [CHANNELS-1:0]           compareOut,
  output logic [CHANNELS-1:0]           tcFlag
);

  logic [PRESCALE_W-1:0]           pc_q, pc_d;
  logic                            strobe;
  logic [CHANNELS-1:0][WIDTH-1:0]  cnt;

  // >= rather than == so lowering the divisor below pc fires on the next tick.
  assign strobe = tick & (pc_q >= prescaleDiv);

  // Prescaler advances only on tick and restarts when it fires.
  always_comb begin
    pc_d = pc_q;
    if (tick) pc_d = strobe ? '0 : pc_q + PRESCALE_W'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clock) begin
    if (!resetN) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Out-of-range cfgChan matches no channel, so the write is dropped.
    logic wr_hit;
    assign wr_hit = cfgWrEn & (32'(cfgChan) == 32'(i));

    counter_channel #(.WIDTH(WIDTH)) u_chan (
      .clk_i     (clock),
      .rst_ni    (resetN),
      .strobe_i  (strobe),
      .enable_i  (chanEnable[i]),
      .load_i    (chanLoad[i]),
      .up_i      (upNotDown[i]),
      .wr_en_i   (wr_hit),
      .wr_reg_i  (cfgReg),
      .wr_data_i (cfgData),
      .count_o   (cnt[i]),
      .compare_o (compareOut[i]),
      .tc_flag_o (tcFlag[i])
    );
  end

  assign countValue = cnt;

endmodule
